// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the I/D cache refill requesters, the arbiter and main memory.
// slave: the arbiter's view. master: the requesters' and memory's view.
interface mem_bus_arbiter_if;
    // I-cache refill side
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic        i_done;
    // D-cache refill / writeback side
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_wnext;
    logic        d_gnt;
    logic        d_rvalid;
    logic        d_done;
    // shared read return
    logic [31:0] rdata;
    // main memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_gnt, i_rvalid, i_done, d_wnext, d_gnt, d_rvalid, d_done, rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_gnt, i_rvalid, i_done, d_wnext, d_gnt, d_rvalid, d_done, rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the single main-memory port shared by the I-cache
// refill path and the D-cache refill/writeback path. Each grant runs one
// fixed-length line burst; read words return registered, one cycle after ack.
module mem_bus_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int OFF_W      = $clog2(LINE_WORDS) + 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              owner_d;     // 0 = I owns the bus, 1 = D owns it
    logic              last_d;      // owner of the most recently completed burst
    logic              we_q;
    logic [31:0]       base;
    logic [31:0]       rdata_q;
    logic              i_rv_q, d_rv_q;

    logic              grant, grant_d;
    logic              in_burst, in_done, busy, last_beat;

    assign in_burst  = (state == BURST);
    assign in_done   = (state == DONE);
    assign busy      = in_burst | in_done;
    assign last_beat = in_burst & bus.mem_ack & (cnt == LAST_CNT);

    // On a tie the side that did not own the previous burst wins.
    assign grant   = bus.i_req | bus.d_req;
    assign grant_d = bus.d_req & (~bus.i_req | ~last_d);

    // State register; reset aborts any burst without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: one burst per grant, one DONE cycle, back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = BURST;
            BURST:   if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Burst context: owner, aligned base, beat counter, read return registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            owner_d <= 1'b0;
            last_d  <= 1'b1;
            we_q    <= 1'b0;
            base    <= '0;
            rdata_q <= '0;
            i_rv_q  <= 1'b0;
            d_rv_q  <= 1'b0;
        end else begin
            i_rv_q <= 1'b0;
            d_rv_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant) begin
                        owner_d <= grant_d;
                        base    <= (grant_d ? bus.d_addr : bus.i_addr) & ALIGN_MASK;
                        we_q    <= grant_d & bus.d_we;
                    end
                end
                BURST: begin
                    if (bus.mem_ack) begin
                        cnt <= cnt + CNT_W'(1);
                        if (!we_q) begin
                            rdata_q <= bus.mem_rdata;
                            i_rv_q  <= ~owner_d;
                            d_rv_q  <= owner_d;
                        end
                    end
                    if (last_beat) last_d <= owner_d;
                end
                DONE:    cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

    // Base is line aligned, so the word offset never carries into the tag.
    assign bus.mem_req   = in_burst;
    assign bus.mem_we    = in_burst & we_q;
    assign bus.mem_addr  = in_burst ? base + {{(30-CNT_W){1'b0}}, cnt, 2'b00} : '0;
    assign bus.mem_wdata = bus.d_wdata;

    assign bus.i_gnt    = busy & ~owner_d;
    assign bus.d_gnt    = busy & owner_d;
    assign bus.i_done   = in_done & ~owner_d;
    assign bus.d_done   = in_done & owner_d;
    assign bus.d_wnext  = in_burst & owner_d & we_q & bus.mem_ack;
    assign bus.i_rvalid = i_rv_q;
    assign bus.d_rvalid = d_rv_q;
    assign bus.rdata    = rdata_q;
endmodule
